// File: rtl/mcm_pkg.sv
// Shared types and reference tables for the odd-part DCT-II constant multiplier.
package mcm_pkg;

  typedef enum logic [1:0] {
    SZ4  = 2'd0,
    SZ8  = 2'd1,
    SZ16 = 2'd2,
    SZ32 = 2'd3
  } dct_sz_e;

  localparam int unsigned NUM_LANES = 16;

  // Odd-row coefficients per transform size, lane 0 first; unused lanes are 0.
  localparam int COEF_TAB [4][16] = '{
    '{83, 36,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0},
    '{89, 75, 50, 18,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0},
    '{90, 87, 80, 70, 57, 43, 25,  9,  0,  0,  0,  0,  0,  0,  0,  0},
    '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13,  4}
  };

  // One bit per populated lane for the given size.
  function automatic logic [15:0] lane_mask(dct_sz_e sz);
    logic [15:0] m;
    m = '0;
    case (sz)
      SZ4:     m = 16'h0003;
      SZ8:     m = 16'h000F;
      SZ16:    m = 16'h00FF;
      SZ32:    m = 16'hFFFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mcm_odd_core.sv
// Combinational back end of the odd-part MCM: turns the registered odd
// partials (x*1, x*3, ..., x*31) into the 16 lane products for one size.
module mcm_odd_core
  import mcm_pkg::*;
#(
  parameter int unsigned OUT_W = 27
) (
  input  logic signed [OUT_W-1:0]    p1,
  input  logic signed [OUT_W-1:0]    p3,
  input  logic signed [OUT_W-1:0]    p5,
  input  logic signed [OUT_W-1:0]    p7,
  input  logic signed [OUT_W-1:0]    p9,
  input  logic signed [OUT_W-1:0]    p11,
  input  logic signed [OUT_W-1:0]    p13,
  input  logic signed [OUT_W-1:0]    p23,
  input  logic signed [OUT_W-1:0]    p27,
  input  logic signed [OUT_W-1:0]    p31,
  input  dct_sz_e                    sz,
  output logic [NUM_LANES*OUT_W-1:0] lanes
);

  logic signed [OUT_W-1:0] c4,  c9,  c13, c18, c22, c25, c31, c36, c38;
  logic signed [OUT_W-1:0] c43, c46, c50, c54, c57, c61, c67, c70, c73;
  logic signed [OUT_W-1:0] c75, c78, c80, c82, c83, c85, c87, c88, c89, c90;
  logic signed [OUT_W-1:0] lane [NUM_LANES];

  assign c4  = p1 <<< 2;
  assign c9  = p9;
  assign c13 = p13;
  assign c18 = p9 <<< 1;
  assign c22 = p11 <<< 1;
  assign c25 = (p3 <<< 3) + p1;
  assign c31 = p31;
  assign c36 = p9 <<< 2;
  assign c38 = (p5 <<< 3) - (p1 <<< 1);
  assign c43 = (p11 <<< 2) - p1;
  assign c46 = p23 <<< 1;
  assign c50 = (p3 <<< 4) + (p1 <<< 1);
  assign c54 = p27 <<< 1;
  assign c57 = (p1 <<< 6) - p7;
  assign c61 = (p1 <<< 6) - p3;
  assign c67 = (p1 <<< 6) + p3;
  assign c70 = (p7 <<< 3) + (p7 <<< 1);
  assign c73 = (p9 <<< 3) + p1;
  assign c75 = (p5 <<< 4) - p5;
  assign c78 = (p13 <<< 2) + (p13 <<< 1);
  assign c80 = p5 <<< 4;
  assign c82 = (p5 <<< 4) + (p1 <<< 1);
  assign c83 = (p5 <<< 4) + p3;
  assign c85 = (p5 <<< 4) + p5;
  assign c87 = (p11 <<< 3) - p1;
  assign c88 = p11 <<< 3;
  assign c89 = (p11 <<< 3) + p1;
  assign c90 = (p11 <<< 3) + (p1 <<< 1);

  // Route the products of the selected size onto lanes; idle lanes read 0.
  always_comb begin
    for (int unsigned k = 0; k < NUM_LANES; k++) lane[k] = '0;
    case (sz)
      SZ4: begin
        lane[0] = c83; lane[1] = c36;
      end
      SZ8: begin
        lane[0] = c89; lane[1] = c75; lane[2] = c50; lane[3] = c18;
      end
      SZ16: begin
        lane[0] = c90; lane[1] = c87; lane[2] = c80; lane[3] = c70;
        lane[4] = c57; lane[5] = c43; lane[6] = c25; lane[7] = c9;
      end
      SZ32: begin
        lane[0]  = c90; lane[1]  = c90; lane[2]  = c88; lane[3]  = c85;
        lane[4]  = c82; lane[5]  = c78; lane[6]  = c73; lane[7]  = c67;
        lane[8]  = c61; lane[9]  = c54; lane[10] = c46; lane[11] = c38;
        lane[12] = c31; lane[13] = c22; lane[14] = c13; lane[15] = c4;
      end
      default: ;
    endcase
    lanes = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) lanes[k*OUT_W +: OUT_W] = lane[k];
  end

endmodule

// File: rtl/mcm_odd_pipe.sv
// Two-stage pipelined multiple-constant multiplier for the odd half of the
// DCT-II butterfly (4/8/16/32 point), valid/ready with a global stall.
// Optional build macro: MCM_ROUND_EN enables round-half-up >>> SHIFT on
// every lane in stage B.
module mcm_odd_pipe
  import mcm_pkg::*;
#(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 27,
  parameter int unsigned SHIFT = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_W-1:0]     in_x,
  input  logic [1:0]                 in_sz,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_LANES*OUT_W-1:0] out_prod,
  output logic [15:0]                out_mask,
  output logic [1:0]                 out_sz
);

  localparam bit CFG_OK = (OUT_W >= IN_W + 7) && (SHIFT >= 1) && (SHIFT <= OUT_W - 2);

  // An out-of-range parameter set shows up as this named scope in the hierarchy.
  if (!CFG_OK) begin : g_cfg_out_of_range
  end

  logic                    adv;
  logic signed [OUT_W-1:0] xe, x22, x26;
  logic signed [OUT_W-1:0] n1, n3, n5, n7, n9, n11, n13, n23, n27, n31;

  logic                    va;
  dct_sz_e                 a_sz;
  logic signed [OUT_W-1:0] a_p1, a_p3, a_p5, a_p7, a_p9;
  logic signed [OUT_W-1:0] a_p11, a_p13, a_p23, a_p27, a_p31;

  logic [NUM_LANES*OUT_W-1:0] raw_lanes;
  logic [NUM_LANES*OUT_W-1:0] prod_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Shared odd partials; x*11 and x*13 come from exact halving of x*22 / x*26.
  always_comb begin
    xe  = {{(OUT_W-IN_W){in_x[IN_W-1]}}, in_x};
    x22 = (xe <<< 4) + (xe <<< 2) + (xe <<< 1);
    x26 = (xe <<< 4) + (xe <<< 3) + (xe <<< 1);
    n1  = xe;
    n3  = xe + (xe <<< 1);
    n5  = xe + (xe <<< 2);
    n7  = (xe <<< 3) - xe;
    n9  = (xe <<< 3) + xe;
    n11 = x22 >>> 1;
    n13 = x26 >>> 1;
    n23 = (xe <<< 4) + n7;
    n27 = (xe <<< 5) - n5;
    n31 = (xe <<< 5) - xe;
  end

  // Stage A: capture the accepted sample's size tag and partials.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va    <= 1'b0;
      a_sz  <= SZ4;
      a_p1  <= '0; a_p3  <= '0; a_p5  <= '0; a_p7  <= '0; a_p9  <= '0;
      a_p11 <= '0; a_p13 <= '0; a_p23 <= '0; a_p27 <= '0; a_p31 <= '0;
    end else if (adv) begin
      va <= in_valid;
      if (in_valid) begin
        a_sz  <= dct_sz_e'(in_sz);
        a_p1  <= n1;  a_p3  <= n3;  a_p5  <= n5;  a_p7  <= n7;  a_p9  <= n9;
        a_p11 <= n11; a_p13 <= n13; a_p23 <= n23; a_p27 <= n27; a_p31 <= n31;
      end
    end
  end

  mcm_odd_core #(
    .OUT_W(OUT_W)
  ) u_core (
    .p1   (a_p1),
    .p3   (a_p3),
    .p5   (a_p5),
    .p7   (a_p7),
    .p9   (a_p9),
    .p11  (a_p11),
    .p13  (a_p13),
    .p23  (a_p23),
    .p27  (a_p27),
    .p31  (a_p31),
    .sz   (a_sz),
    .lanes(raw_lanes)
  );

`ifdef MCM_ROUND_EN
  localparam logic signed [OUT_W:0] RND_BIAS = {{OUT_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic signed [OUT_W:0] rnd_sum [NUM_LANES];
  logic signed [OUT_W:0] rnd_sh  [NUM_LANES];

  // Round half up in one extra bit of headroom, then narrow back to OUT_W.
  always_comb begin
    prod_next = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      rnd_sum[k] = {raw_lanes[k*OUT_W + OUT_W - 1], raw_lanes[k*OUT_W +: OUT_W]} + RND_BIAS;
      rnd_sh[k]  = rnd_sum[k] >>> SHIFT;
      prod_next[k*OUT_W +: OUT_W] = rnd_sh[k][OUT_W-1:0];
    end
  end
`else
  assign prod_next = raw_lanes;
`endif

  // Stage B: present products, mask and size; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_mask  <= '0;
      out_sz    <= '0;
    end else if (adv) begin
      out_valid <= va;
      if (va) begin
        out_prod <= prod_next;
        out_mask <= lane_mask(a_sz);
        out_sz   <= a_sz;
      end
    end
  end

endmodule

// File: tb/tb_mcm_odd_pipe.sv
// Directed self-checking bench for mcm_odd_pipe.
module tb_mcm_odd_pipe;
  import mcm_pkg::*;

  localparam int IN_W  = 17;
  localparam int OUT_W = 27;
  localparam int SHIFT = 7;
  localparam int PW    = 16 * OUT_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] in_x;
  logic [1:0]             in_sz;
  logic                   out_valid;
  logic                   out_ready;
  logic [PW-1:0]          out_prod;
  logic [15:0]            out_mask;
  logic [1:0]             out_sz;

  int total = 0;
  int bad   = 0;

  mcm_odd_pipe #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_sz    (in_sz),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod),
    .out_mask (out_mask),
    .out_sz   (out_sz)
  );

  always #5 clk = ~clk;

  // Reference products by true multiplication against the coefficient table.
  function automatic logic [PW-1:0] model_prod(input int x, input int sz);
    logic [PW-1:0] v;
    longint p;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      p = longint'(COEF_TAB[sz][k]) * longint'(x);
`ifdef MCM_ROUND_EN
      p = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`endif
      v[k*OUT_W +: OUT_W] = p[OUT_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [15:0] model_mask(input int sz);
    case (sz)
      0:       return 16'h0003;
      1:       return 16'h000F;
      2:       return 16'h00FF;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_sz = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_prod !== '0) begin bad++; $display("FAIL reset_prod got=%h want=0", out_prod); end
    total++; if (out_mask !== 16'h0 || out_sz !== 2'd0) begin
      bad++; $display("FAIL reset_mask_sz got=%h/%0d want=0/0", out_mask, out_sz);
    end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  // Issue one beat on an idle pipe and check the exact 2-cycle latency.
  task automatic test_single(input int x, input int sz, input string name, output logic [PW-1:0] got);
    got = 'x;
    @(negedge clk);
    in_valid = 1'b1; in_x = x[IN_W-1:0]; in_sz = sz[1:0]; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s early_valid got=%b want=0", name, out_valid); end
    @(negedge clk);
    got = out_prod;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s valid got=%b want=1", name, out_valid); end
    total++; if (out_prod !== model_prod(x, sz)) begin
      bad++; $display("FAIL %s prod got=%h want=%h", name, out_prod, model_prod(x, sz));
    end
    total++; if (out_mask !== model_mask(sz)) begin bad++; $display("FAIL %s mask got=%h want=%h", name, out_mask, model_mask(sz)); end
    total++; if (out_sz !== sz[1:0]) begin bad++; $display("FAIL %s sz got=%0d want=%0d", name, out_sz, sz); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s drain got=%b want=0", name, out_valid); end
  endtask

  task automatic test_table;
    logic [PW-1:0] g;
    for (int s = 0; s < 4; s++) test_single(1, s, $sformatf("unit_sz%0d", s), g);
  endtask

  task automatic test_extremes;
    logic [PW-1:0] g;
    logic signed [OUT_W-1:0] l;
    test_single(-65536, 3, "min_sz3", g);
`ifndef MCM_ROUND_EN
    l = g[0 +: OUT_W];
    total++; if (l !== -27'sd5898240) begin bad++; $display("FAIL min_sz3_lane0 got=%0d want=-5898240", l); end
    l = g[15*OUT_W +: OUT_W];
    total++; if (l !== -27'sd262144) begin bad++; $display("FAIL min_sz3_lane15 got=%0d want=-262144", l); end
`endif
    test_single(-65536, 0, "min_sz0", g);
`ifndef MCM_ROUND_EN
    l = g[1*OUT_W +: OUT_W];
    total++; if (l !== -27'sd2359296) begin bad++; $display("FAIL min_sz0_lane1 got=%0d want=-2359296", l); end
`endif
    test_single(65535, 3, "max_sz3", g);
    test_single(12345, 2, "mid_sz2", g);
    test_single(-1, 1, "neg1_sz1", g);
    test_single(-777, 0, "neg_sz0", g);
  endtask

  task automatic test_back_to_back;
    int bx[8];
    int bs[8];
    logic ev;
    for (int i = 0; i < 8; i++) begin bx[i] = i * 4099 - 15000; bs[i] = i % 4; end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c < 10);
      total++;
      if (out_valid !== ev) begin
        bad++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, out_valid, ev);
      end else if (ev) begin
        total++;
        if (out_prod !== model_prod(bx[c-2], bs[c-2]) || out_sz !== bs[c-2][1:0]) begin
          bad++; $display("FAIL b2b_beat%0d got=%h/%0d want=%h/%0d", c - 2, out_prod, out_sz,
                          model_prod(bx[c-2], bs[c-2]), bs[c-2]);
        end
      end
      if (c < 8) begin
        in_valid = 1'b1; in_x = bx[c][IN_W-1:0]; in_sz = bs[c][1:0];
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b want=1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall;
    int bx[4];
    int bs[4];
    int sent, got, stalls;
    logic held;
    logic [PW-1:0] held_p;
    logic [15:0] held_m;
    logic [1:0] held_s;
    for (int i = 0; i < 4; i++) begin bx[i] = (i % 2 == 0) ? 1000 * (i + 1) : -1000 * (i + 1); bs[i] = 3 - i; end
    sent = 0; got = 0; stalls = 0; held = 1'b0;
    held_p = '0; held_m = '0; held_s = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (sent < 4);
      if (sent < 4) begin in_x = bx[sent][IN_W-1:0]; in_sz = bs[sent][1:0]; end
      #1;
      if (out_valid === 1'b1 && !out_ready) begin
        stalls++;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b want=0", c, in_ready); end
        if (held) begin
          total++;
          if (out_prod !== held_p || out_mask !== held_m || out_sz !== held_s) begin
            bad++; $display("FAIL stall_hold c=%0d got=%h/%h/%0d want=%h/%h/%0d", c, out_prod, out_mask, out_sz,
                            held_p, held_m, held_s);
          end
        end
        held = 1'b1; held_p = out_prod; held_m = out_mask; held_s = out_sz;
      end else begin
        held = 1'b0;
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (got >= 4) begin
          bad++; $display("FAIL stall_extra_beat c=%0d got=%h want=none", c, out_prod);
        end else if (out_prod !== model_prod(bx[got], bs[got]) || out_sz !== bs[got][1:0]) begin
          bad++; $display("FAIL stall_beat%0d got=%h/%0d want=%h/%0d", got, out_prod, out_sz,
                          model_prod(bx[got], bs[got]), bs[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got !== 4) begin bad++; $display("FAIL stall_count got=%0d want=4", got); end
    total++; if (stalls !== 3) begin bad++; $display("FAIL stall_cycles got=%0d want=3", stalls); end
  endtask

  task automatic test_reset_midstream;
    logic [PW-1:0] g;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_x = 17'(5000 + i); in_sz = 2'd3;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    total++; if (out_prod !== '0 || out_mask !== 16'h0 || out_sz !== 2'd0) begin
      bad++; $display("FAIL midrst_outputs got=%h/%h/%0d want=0/0/0", out_prod, out_mask, out_sz);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale c=%0d got=%b want=0", c, out_valid); end
    end
    test_single(-300, 1, "post_rst", g);
  endtask

`ifdef MCM_ROUND_EN
  task automatic test_round;
    logic [PW-1:0] g;
    logic signed [OUT_W-1:0] l;
    test_single(100, 3, "round_pos", g);
    l = g[0 +: OUT_W];
    total++; if (l !== 27'sd70) begin bad++; $display("FAIL round_pos_lane0 got=%0d want=70", l); end
    test_single(-100, 3, "round_neg", g);
    l = g[0 +: OUT_W];
    total++; if (l !== -27'sd70) begin bad++; $display("FAIL round_neg_lane0 got=%0d want=-70", l); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_table();
    test_extremes();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
`ifdef MCM_ROUND_EN
    test_round();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
